// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-outstanding memory port between the instruction fetch
//   unit (IF) and the load/store unit (LSU). LSU normally has priority, but
//   after LSU_BURST_MAX consecutive LSU grants with a fetch waiting, the fetch
//   is served next so the core cannot starve itself of instructions.
//
//   Optional feature macro: MEM_ARBITER_TIMEOUT_EN
//     defined   : a transfer that sees no MEM_ACK for TIMEOUT_CYCLES cycles is
//                 closed with a VALID pulse carrying RDATA = 0, and the sticky
//                 TIMEOUT_ERR flag is set.
//     undefined : a transfer waits for MEM_ACK indefinitely; TIMEOUT_ERR is 0.
//
//   Ports
//     CLK, RST_N            clock, asynchronous active-low reset
//     IF_REQ/IF_ADDR        fetch request (held until IF_GNT)
//     IF_GNT                one-cycle grant pulse to fetch
//     IF_RDATA/IF_VALID     registered fetch data + one-cycle completion pulse
//     LSU_REQ/WE/BE/ADDR/WDATA  load/store request (held until LSU_GNT)
//     LSU_GNT               one-cycle grant pulse to the LSU
//     LSU_RDATA/LSU_VALID   registered load data + one-cycle completion pulse
//     MEM_REQ/WE/BE/ADDR/WDATA  registered shared memory request
//     MEM_ACK/MEM_RDATA     single-cycle memory completion + read data
//     BUSY                  high while a transfer is in flight
//     TIMEOUT_ERR           sticky ACK-timeout flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int LSU_BURST_MAX  = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_GNT,
    output logic [31:0] IF_RDATA,
    output logic        IF_VALID,
    input  logic        LSU_REQ,
    input  logic        LSU_WE,
    input  logic [3:0]  LSU_BE,
    input  logic [31:0] LSU_ADDR,
    input  logic [31:0] LSU_WDATA,
    output logic        LSU_GNT,
    output logic [31:0] LSU_RDATA,
    output logic        LSU_VALID,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        BUSY,
    output logic        TIMEOUT_ERR
);

    localparam logic [2:0] BURST_MAX_C = 3'(LSU_BURST_MAX);
    localparam logic [7:0] TMO_LAST_C  = 8'(TIMEOUT_CYCLES - 1);
`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam logic       TMO_EN_C    = 1'b1;
`else
    localparam logic       TMO_EN_C    = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_XFER  = 2'd1,
        ST_LSU_XFER = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        rst_done_r;
    logic [2:0]  burst_r;
    logic [7:0]  tmo_cnt_r;
    logic        if_prio_s;
    logic        tmo_hit_s;
    logic        grant_if_s;
    logic        grant_lsu_s;
    logic        ack_s;
    logic        tmo_s;

    // Fetch overrides LSU priority once the LSU has had its burst while IF waited.
    assign if_prio_s = IF_REQ && (burst_r >= BURST_MAX_C);
    // Terminal wait cycle; constant 0 when the timeout feature is not built.
    assign tmo_hit_s = TMO_EN_C && (tmo_cnt_r == TMO_LAST_C);

    // One idle edge after reset release before arbitration is allowed.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_done_r <= 1'b0;
        end else begin
            rst_done_r <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/timeout in XFER.
    always_comb begin
        state_nxt_s = state_r;
        grant_if_s  = 1'b0;
        grant_lsu_s = 1'b0;
        ack_s       = 1'b0;
        tmo_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rst_done_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (LSU_REQ && !if_prio_s) begin
                    grant_lsu_s = 1'b1;
                    state_nxt_s = ST_LSU_XFER;
                end else if (IF_REQ) begin
                    grant_if_s  = 1'b1;
                    state_nxt_s = ST_IF_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IF_XFER, ST_LSU_XFER: begin
                // An ACK in the terminal cycle wins over the timeout.
                if (MEM_ACK) begin
                    ack_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (tmo_hit_s) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Consecutive LSU grants taken while a fetch was waiting.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            burst_r <= 3'd0;
        end else if (grant_if_s) begin
            burst_r <= 3'd0;
        end else if ((state_r == ST_IDLE) && !IF_REQ) begin
            burst_r <= 3'd0;
        end else if (grant_lsu_s && (burst_r != 3'd7)) begin
            burst_r <= burst_r + 3'd1;
        end else begin
            burst_r <= burst_r;
        end
    end

    // Counts XFER cycles; zero in the first cycle of every transfer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt_r <= 8'd0;
        end else if ((state_r == ST_IDLE) || (state_nxt_s == ST_IDLE)) begin
            tmo_cnt_r <= 8'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end
    end

    // Grant/valid pulses and busy flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            IF_GNT    <= 1'b0;
            LSU_GNT   <= 1'b0;
            IF_VALID  <= 1'b0;
            LSU_VALID <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            IF_GNT    <= grant_if_s;
            LSU_GNT   <= grant_lsu_s;
            IF_VALID  <= (ack_s || tmo_s) && (state_r == ST_IF_XFER);
            LSU_VALID <= (ack_s || tmo_s) && (state_r == ST_LSU_XFER);
            BUSY      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Memory request: captured at the grant edge, frozen for the whole transfer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_BE    <= 4'h0;
            MEM_ADDR  <= 32'h0;
            MEM_WDATA <= 32'h0;
        end else if (grant_if_s) begin
            MEM_REQ   <= 1'b1;
            MEM_WE    <= 1'b0;
            MEM_BE    <= 4'hF;
            MEM_ADDR  <= IF_ADDR;
            MEM_WDATA <= 32'h0;
        end else if (grant_lsu_s) begin
            MEM_REQ   <= 1'b1;
            MEM_WE    <= LSU_WE;
            MEM_BE    <= LSU_BE;
            MEM_ADDR  <= LSU_ADDR;
            MEM_WDATA <= LSU_WDATA;
        end else if (ack_s || tmo_s) begin
            MEM_REQ   <= 1'b0;
        end else begin
            MEM_REQ   <= MEM_REQ;
        end
    end

    // Fetch read data: memory data on ACK, zero on timeout.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            IF_RDATA <= 32'h0;
        end else if ((state_r == ST_IF_XFER) && ack_s) begin
            IF_RDATA <= MEM_RDATA;
        end else if ((state_r == ST_IF_XFER) && tmo_s) begin
            IF_RDATA <= 32'h0;
        end else begin
            IF_RDATA <= IF_RDATA;
        end
    end

    // Load read data: stores leave it untouched; timeout forces zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LSU_RDATA <= 32'h0;
        end else if ((state_r == ST_LSU_XFER) && ack_s && !MEM_WE) begin
            LSU_RDATA <= MEM_RDATA;
        end else if ((state_r == ST_LSU_XFER) && tmo_s) begin
            LSU_RDATA <= 32'h0;
        end else begin
            LSU_RDATA <= LSU_RDATA;
        end
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            TIMEOUT_ERR <= 1'b0;
        end else if (tmo_s) begin
            TIMEOUT_ERR <= 1'b1;
        end else begin
            TIMEOUT_ERR <= TIMEOUT_ERR;
        end
    end
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int TMO_CYC = 4;
    localparam int BURST   = 2;
`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam bit TMO_EN  = 1'b1;
`else
    localparam bit TMO_EN  = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic        IF_GNT;
    logic [31:0] IF_RDATA;
    logic        IF_VALID;
    logic        LSU_REQ;
    logic        LSU_WE;
    logic [3:0]  LSU_BE;
    logic [31:0] LSU_ADDR;
    logic [31:0] LSU_WDATA;
    logic        LSU_GNT;
    logic [31:0] LSU_RDATA;
    logic        LSU_VALID;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic        BUSY;
    logic        TIMEOUT_ERR;
    logic        resp_ack;
    logic        stray_ack;

    assign MEM_ACK = resp_ack | stray_ack;

    mem_arbiter #(.TIMEOUT_CYCLES(TMO_CYC), .LSU_BURST_MAX(BURST)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT),
        .IF_RDATA(IF_RDATA), .IF_VALID(IF_VALID),
        .LSU_REQ(LSU_REQ), .LSU_WE(LSU_WE), .LSU_BE(LSU_BE),
        .LSU_ADDR(LSU_ADDR), .LSU_WDATA(LSU_WDATA), .LSU_GNT(LSU_GNT),
        .LSU_RDATA(LSU_RDATA), .LSU_VALID(LSU_VALID),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_if;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        bit          tmo;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_lsu_rdata;
        logic        exp_err;
    } exp_t;

    typedef struct {
        int          delay;
        logic [31:0] data;
    } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    bit          gnt_log[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // reference model state
    int          burst_m;
    logic [31:0] if_rdata_m;
    logic [31:0] lsu_rdata_m;
    logic        err_m;
    bit          last_is_if;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        burst_m     = 0;
        if_rdata_m  = 32'h0;
        lsu_rdata_m = 32'h0;
        err_m       = 1'b0;
    endtask

    // Raise requests, decide the winner from the arbitration rules, queue expectations.
    task automatic issue(input bit new_if, input logic [31:0] ia,
                         input bit new_lsu, input logic we, input logic [3:0] be,
                         input logic [31:0] la, input logic [31:0] wd,
                         input int delay, input logic [31:0] data);
        exp_t        e;
        mem_t        m;
        bit          lsu_wins;
        logic [31:0] r;
        if (new_if && !IF_REQ) begin IF_REQ = 1'b1; IF_ADDR = ia; end
        if (new_lsu && !LSU_REQ) begin
            LSU_REQ = 1'b1; LSU_WE = we; LSU_BE = be; LSU_ADDR = la; LSU_WDATA = wd;
        end
        lsu_wins = LSU_REQ && !(IF_REQ && burst_m >= BURST);
        e.is_if  = !lsu_wins;
        if (e.is_if) begin
            e.addr = IF_ADDR; e.we = 1'b0; e.be = 4'hF; e.wdata = 32'h0;
            burst_m = 0;
        end else begin
            e.addr = LSU_ADDR; e.we = LSU_WE; e.be = LSU_BE; e.wdata = LSU_WDATA;
            burst_m = IF_REQ ? burst_m + 1 : 0;
        end
        e.delay = delay;
        e.tmo   = TMO_EN && (delay >= TMO_CYC);
        r       = e.tmo ? 32'h0 : data;
        if (e.is_if) if_rdata_m = r;
        else if (e.tmo || !e.we) lsu_rdata_m = r;
        err_m   = err_m | e.tmo;
        e.exp_if_rdata  = if_rdata_m;
        e.exp_lsu_rdata = lsu_rdata_m;
        e.exp_err       = err_m;
        m.delay = delay;
        m.data  = data;
        exp_q.push_back(e);
        mem_q.push_back(m);
        last_is_if = e.is_if;
    endtask

    // Expect a grant exactly lat edges later; then the winner drops and scrambles its request.
    task automatic wait_grant(input int lat);
        for (int i = 1; i <= lat; i++) begin
            @(posedge CLK); #1;
            if (i < lat) chk("gnt_early", {IF_GNT, LSU_GNT}, 2'b00);
        end
        chk("gnt_latency", IF_GNT | LSU_GNT, 1'b1);
        if (last_is_if) begin
            IF_REQ = 1'b0; IF_ADDR = $urandom;
        end else begin
            LSU_REQ = 1'b0; LSU_ADDR = $urandom; LSU_WDATA = $urandom;
            LSU_WE = ~LSU_WE; LSU_BE = ~LSU_BE;
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!(IF_VALID || LSU_VALID) && n < 300);
        if (n >= 300) chk("valid_wait", IF_VALID | LSU_VALID, 1'b1);
    endtask

    task automatic round(input bit ni, input logic [31:0] ia, input bit nl, input logic we,
                         input logic [3:0] be, input logic [31:0] la, input logic [31:0] wd,
                         input int delay, input logic [31:0] data);
        issue(ni, ia, nl, we, be, la, wd, delay, data);
        wait_grant(1);
        wait_valid();
    endtask

    task automatic drain();
        while (IF_REQ || LSU_REQ)
            round(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, $urandom_range(0, 3), $urandom);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {IF_GNT, LSU_GNT, IF_VALID, LSU_VALID, MEM_REQ, MEM_WE, BUSY, TIMEOUT_ERR}, 8'h00);
        chk({name, "_rdata"}, {IF_RDATA, LSU_RDATA}, 64'h0);
        chk({name, "_mem"}, {MEM_BE, MEM_ADDR, MEM_WDATA}, 68'h0);
    endtask

    // Memory responder: ACK after the queued delay, garbage read data otherwise.
    initial begin
        bit   in_xfer;
        int   k;
        mem_t m;
        resp_ack  = 1'b0;
        MEM_RDATA = 32'h0;
        in_xfer   = 1'b0;
        k         = 0;
        m.delay   = 255;
        m.data    = 32'h0;
        forever begin
            @(posedge CLK); #1;
            resp_ack  = 1'b0;
            MEM_RDATA = $urandom;
            if (RST_N && MEM_REQ) begin
                if (!in_xfer) begin
                    in_xfer = 1'b1;
                    k = 0;
                    if (mem_q.size() > 0) m = mem_q.pop_front();
                    else begin m.delay = 255; m.data = 32'h0; end
                end else begin
                    k++;
                end
                if (k == m.delay) begin
                    resp_ack  = 1'b1;
                    MEM_RDATA = m.data;
                end
            end else begin
                in_xfer = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every grant and checks every completion.
    initial begin
        exp_t cur;
        bit   have;
        bit   stable_bad;
        int   req_cyc;
        have = 1'b0; stable_bad = 1'b0; req_cyc = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                have = 1'b0;
            end else begin
                if (IF_GNT || LSU_GNT) begin
                    if (have || exp_q.size() == 0) begin
                        chk("unexpected_gnt", {IF_GNT, LSU_GNT}, 2'b00);
                    end else begin
                        cur = exp_q.pop_front();
                        have = 1'b1; req_cyc = 0; stable_bad = 1'b0;
                        gnt_log.push_back(IF_GNT);
                        chk("gnt_owner", {IF_GNT, LSU_GNT}, {cur.is_if, !cur.is_if});
                        chk("mem_fields", {MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA},
                            {1'b1, cur.we, cur.be, cur.addr, cur.wdata});
                    end
                end
                if (have && MEM_REQ) begin
                    req_cyc++;
                    if ({MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA} !== {cur.we, cur.be, cur.addr, cur.wdata})
                        stable_bad = 1'b1;
                end
                if (IF_VALID || LSU_VALID) begin
                    if (!have) begin
                        chk("unexpected_valid", {IF_VALID, LSU_VALID}, 2'b00);
                    end else begin
                        chk("valid_owner", {IF_VALID, LSU_VALID}, {cur.is_if, !cur.is_if});
                        chk("if_rdata", IF_RDATA, cur.exp_if_rdata);
                        chk("lsu_rdata", LSU_RDATA, cur.exp_lsu_rdata);
                        chk("req_cycles", req_cyc, cur.tmo ? TMO_CYC : cur.delay + 1);
                        chk("mem_req_drop", MEM_REQ, 1'b0);
                        chk("mem_stable", stable_bad, 1'b0);
                        chk("timeout_err", TIMEOUT_ERR, cur.exp_err);
                        have = 1'b0;
                    end
                end
                chk("busy", BUSY, have);
            end
        end
    end

    // Stimulus.
    initial begin
        int base;
        RST_N = 1'b0; IF_REQ = 1'b0; IF_ADDR = 32'h0; LSU_REQ = 1'b0; LSU_WE = 1'b0;
        LSU_BE = 4'h0; LSU_ADDR = 32'h0; LSU_WDATA = 32'h0; stray_ack = 1'b0;
        last_is_if = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 chk_all_zero("reset");
        @(negedge CLK); #2 RST_N = 1'b1;
        repeat (3) @(posedge CLK); #1;

        // Single fetch, immediate ACK.
        round(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0050_0093);
        chk("fetch_0x100", IF_RDATA, 32'h0050_0093);

        // Both requesters held: LSU, LSU, IF, LSU.
        base = gnt_log.size();
        for (int i = 0; i < 4; i++)
            round(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0, 4'hF, 32'h800 + 32'(4 * i), 32'h0,
                  0, $urandom);
        if (gnt_log.size() >= base + 4)
            chk("burst_order", {gnt_log[base], gnt_log[base + 1], gnt_log[base + 2], gnt_log[base + 3]},
                4'b0010);
        else
            chk("burst_order_count", gnt_log.size(), base + 4);
        drain();

        // Store, ACK in the third transfer cycle; load data must survive.
        round(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF, 2, $urandom);

        // Stray ACK while idle must do nothing.
        stray_ack = 1'b1;
        @(posedge CLK); #1 stray_ack = 1'b0;
        repeat (2) @(posedge CLK); #1;
        chk("stray_ack_rdata", {IF_RDATA, LSU_RDATA}, {if_rdata_m, lsu_rdata_m});

        // Reset in the middle of a load: abandoned, outputs cleared at once.
        issue(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 200, $urandom);
        wait_grant(1);
        repeat (2) @(posedge CLK);
        @(negedge CLK); #2 RST_N = 1'b0;
        #1 chk_all_zero("rst_mid_xfer");
        model_reset();
        @(negedge CLK); #2 RST_N = 1'b1;
        issue(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, $urandom);
        wait_grant(2);
        wait_valid();

        // Randomized traffic.
        for (int r = 0; r < 60; r++) begin
            bit ni, nl;
            ni = ($urandom_range(0, 9) < 7);
            nl = ($urandom_range(0, 9) < 7);
            if (!ni && !nl && !IF_REQ && !LSU_REQ) nl = 1'b1;
            round(ni, $urandom & 32'hFFFF_FFFC, nl, 1'($urandom_range(0, 1)),
                  4'($urandom_range(1, 15)), $urandom & 32'hFFFF_FFFC, $urandom,
                  $urandom_range(0, 3), $urandom);
        end
        drain();

`ifdef MEM_ARBITER_TIMEOUT_EN
        // ACK in the terminal cycle completes normally; no ACK times out.
        round(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, TMO_CYC - 1, 32'h1234_5678);
        chk("ack_last_cycle_err", TIMEOUT_ERR, 1'b0);
        round(1'b1, 32'h504, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 255, 32'h0);
        chk("timeout_rdata", {IF_RDATA, TIMEOUT_ERR}, {32'h0, 1'b1});
        round(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1, 32'hCAFE_F00D);
        chk("timeout_sticky", TIMEOUT_ERR, 1'b1);
`endif

        // Final reset clears everything, including the error flag.
        @(negedge CLK); #2 RST_N = 1'b0;
        #1 chk_all_zero("final_reset");
        @(negedge CLK); #2 RST_N = 1'b1;
        repeat (2) @(posedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
